uart_rom_loader: RTL and testbench

- Boot-load controller that sequences the UART receiver and writes a program image into instruction ROM/RAM.
- Arms and disarms the receiver, parses a framed byte stream into 16-bit words and issues ROM write strobes.
- Validates the frame (length and checksum), enforces an inter-byte timeout and holds the CPU in reset while loading.
- Sits between uart_receiver (is_valid/data/got_break) and the ROM write port / CPU reset.

---
 rtl/uart_loader_pkg.sv | 25 ++
 rtl/loader_timeout_timer.sv | 29 ++
 rtl/uart_rom_loader.sv | 191 +++++++++++++++++++
 tb/tb_uart_rom_loader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot-load controller.
// Loader state encoding, abort reason codes and the default frame-open command byte.
package uart_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_CMD,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_CSUM    = 3'd2;
    localparam logic [2:0] ERR_BREAK   = 3'd3;
    localparam logic [2:0] ERR_LEN     = 3'd4;

    localparam logic [7:0] CMD_LOAD_DEF = 8'h4C;

endpackage

// File: rtl/loader_timeout_timer.sv
// Inter-byte watchdog: counts while run is high, restarts on clear and
// flags expiry once TIMEOUT_CYCLES-1 idle cycles have elapsed.
module loader_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (run) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign expired = run && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_rom_loader.sv
// Boot-load controller: parses CMD/LEN/data/CSUM frames from the UART receiver,
// writes 16-bit words into instruction ROM and holds the CPU in reset meanwhile.
module uart_rom_loader
    import uart_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 15,
    parameter int          WORD_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
    parameter logic [7:0]  CMD_LOAD       = CMD_LOAD_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  rx_break,
    output logic                  rx_enable,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [WORD_WIDTH-1:0] rom_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            err_code,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [7:0]            csum_q, csum_d;
    logic [7:0]            hi_q, hi_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic                  rom_we_q, rom_we_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [WORD_WIDTH-1:0] rom_wdata_q, rom_wdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [2:0]            err_code_q, err_code_d;
    logic                  cpu_hold_q, cpu_hold_d;

    logic                  busy_w;
    logic                  tmr_run;
    logic                  tmr_expired;
    logic [15:0]           len_full;
    logic [ADDR_WIDTH:0]   words_inc;

    assign busy_w    = state_q inside {S_WAIT_CMD, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK};
    assign tmr_run   = state_q inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK};
    assign len_full  = {len_q[15:8], rx_data};
    assign words_inc = words_q + (ADDR_WIDTH + 1)'(1);

    // Idle states hold the counter at zero, so entry to LEN_HI always starts fresh.
    loader_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .clear  (rx_valid || !tmr_run),
        .run    (tmr_run),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        csum_d      = csum_q;
        hi_d        = hi_q;
        words_d     = words_q;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;
        done_d      = done_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        cpu_hold_d  = cpu_hold_q;

        // Break outranks a coincident byte, which outranks a timeout.
        if (busy_w && rx_break) begin
            state_d    = S_ERROR;
            err_d      = 1'b1;
            err_code_d = ERR_BREAK;
        end else if (!busy_w) begin
            if (start) begin
                state_d    = S_WAIT_CMD;
                done_d     = 1'b0;
                err_d      = 1'b0;
                err_code_d = ERR_NONE;
                words_d    = '0;
                csum_d     = '0;
                len_d      = '0;
                cpu_hold_d = 1'b1;
            end
        end else if (rx_valid) begin
            unique case (state_q)
                S_WAIT_CMD: begin
                    if (rx_data == CMD_LOAD) state_d = S_LEN_HI;
                end
                S_LEN_HI: begin
                    len_d   = {rx_data, 8'h00};
                    csum_d  = csum_q + rx_data;
                    state_d = S_LEN_LO;
                end
                S_LEN_LO: begin
                    len_d  = len_full;
                    csum_d = csum_q + rx_data;
                    if (32'(len_full) > (32'd1 << ADDR_WIDTH)) begin
                        state_d    = S_ERROR;
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    hi_d    = rx_data;
                    csum_d  = csum_q + rx_data;
                    state_d = S_DATA_LO;
                end
                S_DATA_LO: begin
                    csum_d      = csum_q + rx_data;
                    rom_we_d    = 1'b1;
                    rom_addr_d  = words_q[ADDR_WIDTH-1:0];
                    rom_wdata_d = WORD_WIDTH'({hi_q, rx_data});
                    words_d     = words_inc;
                    state_d     = (32'(words_inc) == 32'(len_q)) ? S_CHECK : S_DATA_HI;
                end
                S_CHECK: begin
                    if (rx_data == csum_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d    = S_ERROR;
                        err_d      = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                end
                default: state_d = state_q;
            endcase
        end else if (tmr_expired) begin
            state_d    = S_ERROR;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            csum_q      <= '0;
            hi_q        <= '0;
            words_q     <= '0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            cpu_hold_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            csum_q      <= csum_d;
            hi_q        <= hi_d;
            words_q     <= words_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            cpu_hold_q  <= cpu_hold_d;
        end
    end

    assign rx_enable    = busy_w;
    assign busy         = busy_w;
    assign rom_we       = rom_we_q;
    assign rom_addr     = rom_addr_q;
    assign rom_wdata    = rom_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_uart_rom_loader.sv
// Self-checking bench for uart_rom_loader: table-driven frames with a ROM-write
// scoreboard, plus hand-written timeout, break, busy-start and reset sequences.
module tb_uart_rom_loader;

    localparam int AW    = 4;
    localparam int TO    = 100;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_break;
    logic          rx_enable;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          err;
    logic [2:0]    err_code;
    logic [AW:0]   words_loaded;

    uart_rom_loader #(
        .ADDR_WIDTH    (AW),
        .WORD_WIDTH    (16),
        .TIMEOUT_CYCLES(TO),
        .CMD_LOAD      (8'h4C)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_break    (rx_break),
        .rx_enable   (rx_enable),
        .rom_we      (rom_we),
        .rom_addr    (rom_addr),
        .rom_wdata   (rom_wdata),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [AW+15:0] sb[$];

    int          m_phase;
    int          m_len;
    int          m_idx;
    logic [7:0]  m_hi;
    logic [15:0] m_lenw;

    typedef struct {
        int          n;
        logic [95:0] bytes;
        logic        done;
        logic        err;
        logic [2:0]  code;
        int          words;
        logic        hold;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_len   = 0;
        m_idx   = 0;
        m_hi    = 8'h00;
        m_lenw  = 16'h0000;
    endtask

    // Frame parser model: pushes the ROM write each completed word should cause.
    task automatic model_byte(input logic [7:0] b);
        logic [AW-1:0] a;
        case (m_phase)
            0: if (b == 8'h4C) m_phase = 1;
            1: begin m_lenw[15:8] = b; m_phase = 2; end
            2: begin
                m_lenw[7:0] = b;
                m_len = int'(m_lenw);
                if (m_len > DEPTH) m_phase = 9;
                else if (m_len == 0) m_phase = 5;
                else m_phase = 3;
            end
            3: begin m_hi = b; m_phase = 4; end
            4: begin
                a = m_idx[AW-1:0];
                sb.push_back({a, m_hi, b});
                m_idx++;
                m_phase = (m_idx == m_len) ? 5 : 3;
            end
            default: m_phase = 9;
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic pulse_start(input string tag);
        model_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_start_busy"}, busy, 1);
        chk({tag, "_start_hold"}, cpu_hold, 1);
        chk({tag, "_start_clr"}, {done, err, err_code, 5'(words_loaded)}, 0);
    endtask

    always @(negedge clk) begin
        if (resetn && rom_we) begin
            if (sb.size() == 0) begin
                chk("unexpected_rom_we", {rom_addr, rom_wdata}, 32'hFFFF_FFFF);
            end else begin
                chk("rom_write", {rom_addr, rom_wdata}, sb.pop_front());
                chk("words_at_we", words_loaded, 32'(rom_addr) + 1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [7:0]  lo;

        vecs[0] = '{8,  96'h4C00021234ABCDC0,     1'b1, 1'b0, 3'd0, 2, 1'b0};
        vecs[1] = '{8,  96'h4C00021234ABCDC1,     1'b0, 1'b1, 3'd2, 2, 1'b1};
        vecs[2] = '{4,  96'h4C000000,             1'b1, 1'b0, 3'd0, 0, 1'b0};
        vecs[3] = '{3,  96'h4C0011,               1'b0, 1'b1, 3'd4, 0, 1'b1};
        vecs[4] = '{8,  96'h55AA4C0001BEEFAE,     1'b1, 1'b0, 3'd0, 1, 1'b0};
        vecs[5] = '{10, 96'h4C000301020304050618, 1'b1, 1'b0, 3'd0, 3, 1'b0};

        resetn = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_break = 1'b0;
        model_reset();
        #3;
        chk("reset_outputs", {rx_enable, rom_we, rom_addr, rom_wdata, cpu_hold, busy, done, err, err_code, words_loaded}, 0);
        tick(); tick();
        resetn = 1'b1;
        tick();
        chk("post_reset_idle", {busy, cpu_hold, done, err}, 0);

        for (int v = 0; v < 6; v++) begin
            pulse_start($sformatf("vec%0d", v));
            for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].bytes[(vecs[v].n - 1 - i) * 8 +: 8]);
            tick();
            chk($sformatf("vec%0d_done", v), done, vecs[v].done);
            chk($sformatf("vec%0d_err", v), err, vecs[v].err);
            chk($sformatf("vec%0d_code", v), err_code, vecs[v].code);
            chk($sformatf("vec%0d_words", v), words_loaded, vecs[v].words);
            chk($sformatf("vec%0d_hold", v), cpu_hold, vecs[v].hold);
            chk($sformatf("vec%0d_rxen", v), {busy, rx_enable}, 0);
            chk($sformatf("vec%0d_sb_empty", v), sb.size(), 0);
            $display("vec%0d: done=%0d err=%0d code=%0d words=%0d", v, done, err, err_code, words_loaded);
        end

        // Full-depth load: every address written once, no wrap.
        pulse_start("full");
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h10);
        cs = 8'h10;
        for (int i = 0; i < DEPTH; i++) begin
            b  = 8'(i);
            lo = 8'hF0 ^ 8'(i);
            cs = cs + b + lo;
            send_byte(b);
            send_byte(lo);
        end
        send_byte(cs);
        tick();
        chk("full_done", {done, err}, 2'b10);
        chk("full_words", words_loaded, DEPTH);
        chk("full_sb_empty", sb.size(), 0);
        $display("full: done=%0d words=%0d", done, words_loaded);

        // Inter-byte timeout while waiting for the low byte.
        pulse_start("tmo");
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h01);
        model_byte(8'h12);
        rx_valid = 1'b1; rx_data = 8'h12;
        tick();
        rx_valid = 1'b0;
        n = 0;
        while (!err && n < 3 * TO) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, TO);
        chk("tmo_code", err_code, 1);
        chk("tmo_state", {done, cpu_hold, rx_enable}, 3'b010);
        chk("tmo_words", words_loaded, 0);
        $display("timeout: cycles=%0d code=%0d", n, err_code);

        // Break during DATA_LO.
        pulse_start("brk");
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB);
        rx_break = 1'b1;
        tick();
        rx_break = 1'b0;
        chk("brk_err", {err, err_code}, {1'b1, 3'd3});
        chk("brk_rxen", rx_enable, 0);
        chk("brk_words", words_loaded, 1);
        $display("break: code=%0d rx_enable=%0d", err_code, rx_enable);

        // Break coincident with the low byte: no write may happen.
        pulse_start("brkv");
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
        rx_valid = 1'b1; rx_data = 8'h34; rx_break = 1'b1;
        tick();
        rx_valid = 1'b0; rx_break = 1'b0;
        chk("brkv_code", err_code, 3);
        tick(); tick();
        chk("brkv_words", words_loaded, 0);
        $display("break+valid: code=%0d words=%0d", err_code, words_loaded);

        // Break while still waiting for the command byte.
        pulse_start("brkw");
        send_byte(8'h55);
        rx_break = 1'b1;
        tick();
        rx_break = 1'b0;
        chk("brkw_code", {err, err_code}, {1'b1, 3'd3});
        $display("break in WAIT_CMD: code=%0d", err_code);

        // start while busy is ignored.
        pulse_start("sbusy");
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h01);
        start = 1'b1; tick(); start = 1'b0;
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h66);
        tick();
        chk("sbusy_done", {done, err}, 2'b10);
        chk("sbusy_words", words_loaded, 1);
        $display("start-while-busy: done=%0d words=%0d", done, words_loaded);

        // Asynchronous reset mid-frame.
        pulse_start("rst");
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_outputs", {rx_enable, rom_we, rom_addr, rom_wdata, cpu_hold, busy, done, err, err_code, words_loaded}, 0);
        tick();
        resetn = 1'b1;
        tick();
        chk("rst_idle", {busy, cpu_hold}, 0);
        $display("reset mid-frame: busy=%0d cpu_hold=%0d", busy, cpu_hold);

        chk("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
